fdiv_seq: RTL and testbench
===========================

Name: fdiv_seq

Overview:
Sequencer for the one-hot divide-by-4 stage. The divider is a 4-state ring: `c_up` advances it, `clr` forces it to S0, and `fdclk` is high only in S0. On a start command this block clears the divider and issues a paced burst of `c_up` pulses that produces exactly N output periods. It checks the divider's `fdclk` against its own internal phase model and reports done, abort or error. It sits between the control/register logic and the divider.

Parameters:
NW, 8, width of the period-count request and of `period_cnt`
PW, 4, width of the prescaler (gap between `c_up` pulses)

Ports:
clk  in  1  system clock, rising edge
rst_b  in  1  asynchronous active-low reset
start  in  1  request a burst; sampled only in IDLE
abort  in  1  cancel the running burst; sampled in CLEAR/RUN/WAIT
n_periods  in  NW  number of `fdclk` periods to generate; latched on an accepted start
presc  in  PW  `c_up` spacing minus 1; latched on an accepted start
fdclk  in  1  divider output (high when the divider is in S0)
c_up  out  1  advance pulse to the divider
clr  out  1  synchronous clear to the divider
busy  out  1  high in CLEAR, RUN, WAIT, ABORT
done  out  1  one-cycle pulse on normal completion
err  out  1  sticky phase-mismatch flag
period_cnt  out  NW  valid `fdclk` rising edges counted in the current burst

Behaviour:
- Reset (async, `rst_b`=0):
  - state=IDLE.
  - `c_up`, `clr`, `busy`, `done`, `err` = 0; `period_cnt`=0.
  - `fdclk_q`=1; phase ph=0; pulse counter=0; prescaler counter=0.
- Registered `fdclk_q` tracks `fdclk`. It is forced to 1 in the CLEAR cycle. `rise` = `fdclk` & ~`fdclk_q`, evaluated only in RUN and WAIT.
- IDLE:
  - `start`=1 with `n_periods`≠0 -> CLEAR. Latch N and P; clear `err`, `period_cnt`, ph and the pulse counter.
  - `start`=1 with `n_periods`=0 -> DONE directly. `period_cnt`=0; `err` is cleared; no `clr` is issued.
- CLEAR (1 cycle): `clr`=1; prescaler counter <= P; -> RUN.
- RUN:
  - Prescaler counter at 0: `c_up`=1, reload P, ph <= ph+1, pulse counter +1. Otherwise decrement, `c_up`=0.
  - The first pulse falls in RUN cycle P (0-based); pulses are spaced P+1 cycles apart.
  - After the 4N-th pulse -> WAIT. RUN lasts exactly 4N·(P+1) cycles.
- WAIT (1 cycle): `c_up`=0. `rise` is expected this cycle. -> DONE, or ABORT on error or abort.
- Phase check (RUN/WAIT):
  - A `rise` is required in exactly the cycle after each pulse that wraps ph from 3 to 0.
  - A valid rise increments `period_cnt`.
  - A rise at any other time, or a missing rise in that cycle, sets `err`=1 and the next state is ABORT.
- DONE (1 cycle): `done`=1; -> IDLE. `period_cnt` holds until the next accepted start.
- ABORT (1 cycle): `clr`=1, `c_up`=0; -> IDLE. `done` is not asserted. `period_cnt` keeps its partial value.
- Priority in CLEAR/RUN/WAIT: `abort` > `err` detection > normal transition.
  - `abort` takes effect on the next edge; `c_up` may still be 1 in the cycle `abort` is sampled.
  - `abort` in IDLE or DONE is ignored.
- `start` outside IDLE is ignored; there is no queuing.
- `c_up` and `clr` are never both 1.
- `err` stays set until the next accepted start or reset.
- Reset mid-burst: all state returns immediately to reset values. The divider's own reset is separate; no `clr` is issued.
- Counters are sized to hold 4·(2^NW − 1) pulses without wrap.

Test Plan:
- Reset, then `start` with N=1, P=0 → `clr`=1 in cycle 1; `c_up`=1 in cycles 2–5; `rise` in cycle 6 (WAIT); `done`=1 in cycle 7 with `period_cnt`=1; `busy` low from cycle 7.
- N=3, P=2 → exactly 12 `c_up` pulses, each followed by 2 idle cycles; RUN is 36 cycles; `period_cnt` steps 1, 2, 3; `done` pulses once; `err`=0.
- N=5, P=0, `abort` asserted in the 7th RUN cycle → next cycle ABORT with `clr`=1; then IDLE; `done` never pulses; `period_cnt`=1.
- Bench model holds `fdclk`=0 while the divider is in S0 → missing rise after the 4th pulse sets `err`=1; ABORT with `clr`=1; `err` stays 1 until the next `start`, which clears it.
- `start` with N=0 → `done`=1 on the next cycle; no `clr` or `c_up`; `period_cnt`=0. A `start` pulsed during RUN is ignored and `period_cnt` still ends at the original N.
- Assert `rst_b`=0 mid-RUN with N=4, P=1 → `c_up`, `busy`, `period_cnt` go to 0 asynchronously; after release, a new N=1 burst completes normally.

Source files
------------

// File: rtl/fdiv_seq.sv
// Burst sequencer for the one-hot divide-by-4 stage: clears the divider, paces
// c_up pulses to produce N fdclk periods, and cross-checks fdclk against its own phase model.
module fdiv_seq #(
    parameter int NW = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic          abort,
    input  logic [NW-1:0] n_periods,
    input  logic [PW-1:0] presc,
    input  logic          fdclk,
    output logic          c_up,
    output logic          clr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [NW-1:0] period_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        WAIT,
        DONE,
        ABORT
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [NW-1:0]   n_lat;
    logic [PW-1:0]   p_lat;
    logic [PW-1:0]   pre_cnt;
    logic [NW+1:0]   pulse_cnt;
    logic [1:0]      ph;
    logic            fdclk_q;
    logic            expect_q;
    logic            check_en;
    logic            rise;
    logic            mismatch;
    logic            last_pulse;

    assign check_en   = (state == RUN) || (state == WAIT);
    assign rise       = fdclk & ~fdclk_q;
    // A rise is legal only in the cycle right after the pulse that wraps the ring back to S0.
    assign mismatch   = check_en && (rise != expect_q);
    assign last_pulse = ((pulse_cnt + (NW+2)'(1)) == {n_lat, 2'b00});

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        c_up       = 1'b0;
        clr        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (n_periods != '0) ? CLEAR : DONE;
                end
            end
            CLEAR: begin
                clr        = 1'b1;
                busy       = 1'b1;
                next_state = abort ? ABORT : RUN;
            end
            RUN: begin
                busy = 1'b1;
                c_up = (pre_cnt == '0);
                if (abort || mismatch) begin
                    next_state = ABORT;
                end else if (c_up && last_pulse) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                busy       = 1'b1;
                next_state = (abort || mismatch) ? ABORT : DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            ABORT: begin
                clr        = 1'b1;
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            n_lat      <= '0;
            p_lat      <= '0;
            pre_cnt    <= '0;
            pulse_cnt  <= '0;
            ph         <= 2'd0;
            fdclk_q    <= 1'b1;
            expect_q   <= 1'b0;
            err        <= 1'b0;
            period_cnt <= '0;
        end else begin
            // The divider is freshly cleared after CLEAR, so its high fdclk must not read as a rise.
            fdclk_q  <= (state == CLEAR) ? 1'b1 : fdclk;
            expect_q <= c_up && (ph == 2'd3);

            if (state == IDLE && start) begin
                n_lat      <= n_periods;
                p_lat      <= presc;
                err        <= 1'b0;
                period_cnt <= '0;
                ph         <= 2'd0;
                pulse_cnt  <= '0;
            end

            if (state == CLEAR) begin
                pre_cnt <= p_lat;
            end else if (state == RUN) begin
                pre_cnt <= (pre_cnt == '0) ? p_lat : pre_cnt - PW'(1);
            end

            if (c_up) begin
                ph        <= ph + 2'd1;
                pulse_cnt <= pulse_cnt + (NW+2)'(1);
            end

            if (check_en && rise && expect_q) begin
                period_cnt <= period_cnt + NW'(1);
            end

            if (mismatch && !abort) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: a behavioural divide-by-4 ring drives fdclk,
// and per-cycle expectations come from closed-form burst timing arithmetic.
module tb_fdiv_seq;

    localparam int NW = 8;
    localparam int PW = 4;

    logic          clk;
    logic          rst_b;
    logic          start;
    logic          abort;
    logic [NW-1:0] n_periods;
    logic [PW-1:0] presc;
    logic          fdclk;
    logic          c_up;
    logic          clr;
    logic          busy;
    logic          done;
    logic          err;
    logic [NW-1:0] period_cnt;

    int            vectors;
    int            miscompares;
    logic [1:0]    div_state;
    logic          hold_low;

    fdiv_seq #(.NW(NW), .PW(PW)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (start),
        .abort      (abort),
        .n_periods  (n_periods),
        .presc      (presc),
        .fdclk      (fdclk),
        .c_up       (c_up),
        .clr        (clr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .period_cnt (period_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: 4-state ring, hold_low forces fdclk low to fake a broken divider.
    always @(posedge clk) begin
        if (clr) div_state <= 2'd0;
        else if (c_up) div_state <= div_state + 2'd1;
    end
    assign fdclk = (div_state == 2'd0) && !hold_low;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wrap k's valid rise lands in cycle 2+4k(P+1); the count shows one cycle later.
    function automatic int exp_periods(input int n, input int p, input int upto);
        int cnt;
        cnt = 0;
        for (int k = 1; k <= n; k++) begin
            if (3 + 4 * k * (p + 1) <= upto) cnt++;
        end
        return cnt;
    endfunction

    // Cycle 0 presents start; cycle 1 is the clear; RUN covers cycles 2..1+L.
    task automatic run_burst(input int n, input int p, input int abort_run, input int restart_run);
        int  len;
        int  last;
        int  ab;
        bit  in_ab;
        bit  after_ab;
        logic e_cup;
        len = 4 * n * (p + 1);
        ab  = (abort_run >= 0) ? 3 + abort_run : -1;
        last = (abort_run >= 0) ? ab + 1 : 4 + len;
        start     = 1'b1;
        n_periods = NW'(n);
        presc     = PW'(p);
        tick();
        start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            in_ab    = (ab >= 0) && (c == ab);
            after_ab = (ab >= 0) && (c > ab);
            e_cup = !in_ab && !after_ab && c >= 2 && c < 2 + len && ((c - 2) % (p + 1) == p);
            check("clr", clr, (c == 1) || in_ab);
            check("c_up", c_up, e_cup);
            check("busy", busy, (c <= 2 + len) && !after_ab);
            check("done", done, (ab < 0) && (c == 3 + len));
            check("err", err, 0);
            check("period_cnt", period_cnt,
                  exp_periods(n, p, (ab >= 0 && c > ab) ? ab : c));
            abort = (abort_run >= 0) && (c == 2 + abort_run);
            start = (restart_run >= 0) && (c == 2 + restart_run);
            if (start) n_periods = NW'($urandom_range(1, 9));
            tick();
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int n;
        int p;
        vectors     = 0;
        miscompares = 0;
        div_state   = 2'd0;
        hold_low    = 1'b0;
        rst_b       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        n_periods   = '0;
        presc       = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_cup", c_up, 0);
        check("rst_clr", clr, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_pcnt", period_cnt, 0);
        @(negedge clk);
        rst_b = 1'b1;
        tick();

        run_burst(1, 0, -1, -1);
        run_burst(3, 2, -1, -1);
        run_burst(5, 0, 6, -1);
        check("abort_pcnt", period_cnt, 1);

        // Zero-length request completes immediately without touching the divider.
        start     = 1'b1;
        n_periods = '0;
        presc     = 4'd3;
        tick();
        start = 1'b0;
        check("n0_done", done, 1);
        check("n0_clr", clr, 0);
        check("n0_cup", c_up, 0);
        check("n0_busy", busy, 0);
        check("n0_pcnt", period_cnt, 0);
        tick();
        check("n0_done_after", done, 0);

        run_burst(2, 1, -1, 5);

        // Missing rise after the 4th pulse of N=2, P=0 is caught in cycle 6.
        hold_low  = 1'b1;
        start     = 1'b1;
        n_periods = 8'd2;
        presc     = 4'd0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("e_clr", clr, (c == 1) || (c == 7));
            check("e_err", err, c >= 7);
            check("e_busy", busy, c <= 7);
            check("e_done", done, 0);
            tick();
        end
        hold_low = 1'b0;
        tick();
        tick();
        check("e_err_sticky", err, 1);
        check("e_pcnt", period_cnt, 0);
        run_burst(1, 1, -1, -1);

        for (int i = 0; i < 5; i++) begin
            n = $urandom_range(1, 4);
            p = $urandom_range(0, 3);
            run_burst(n, p, -1, -1);
        end

        // Asynchronous reset in the middle of a N=4, P=1 burst.
        start     = 1'b1;
        n_periods = 8'd4;
        presc     = 4'd1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 13; c++) tick();
        check("mr_cup_before", c_up, 1);
        check("mr_busy_before", busy, 1);
        check("mr_pcnt_before", period_cnt, 1);
        rst_b = 1'b0;
        #2;
        check("mr_cup", c_up, 0);
        check("mr_busy", busy, 0);
        check("mr_pcnt", period_cnt, 0);
        check("mr_clr", clr, 0);
        tick();
        rst_b = 1'b1;
        tick();
        run_burst(1, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
